// File: rtl/matmul_c_reader_pkg.sv
// Shared definitions for the matrix-C readback path.
// Holds the tile geometry, the BRAM address widths, the controller state encoding
// (shared with the matmul top-level controller) and the row address helper.
package matmul_c_reader_pkg;

    localparam int unsigned DWIDTH            = 8;
    localparam int unsigned MAT_MUL_SIZE      = 4;
    localparam int unsigned AWIDTH            = 10;
    localparam int unsigned ADDR_STRIDE_WIDTH = 8;
    localparam int unsigned LOG2_MAT_MUL_SIZE = $clog2(MAT_MUL_SIZE);
    localparam int unsigned MASK_WIDTH        = MAT_MUL_SIZE;

    // One BRAM word holds one full row of the tile.
    localparam int unsigned ROW_BITS   = MAT_MUL_SIZE * DWIDTH;
    // Buffered beat: {row index, last flag, row data}.
    localparam int unsigned FIFO_WIDTH = ROW_BITS + LOG2_MAT_MUL_SIZE + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } mm_state_e;

    // Byte address of a row; wraps modulo 2^AWIDTH by construction.
    function automatic logic [AWIDTH-1:0] row_byte_addr(
        input logic [AWIDTH-1:0]            base,
        input logic [ADDR_STRIDE_WIDTH-1:0] stride,
        input logic [LOG2_MAT_MUL_SIZE-1:0] row
    );
        return base + AWIDTH'(row) * AWIDTH'(stride);
    endfunction

endpackage

// File: rtl/mm_rd_fifo.sv
// Synchronous FIFO buffering read rows between the C BRAM and the output stream.
// Ports:
//   clk, resetn  clock, synchronous active-low reset (flushes pointers and count)
//   push, wdata  write strobe / data; accepted when not full, or when full and popping
//   pop          read strobe; ignored when empty
//   rdata        head entry (registered storage, valid while !empty)
//   full, empty  occupancy flags
//   count        current number of entries
module mm_rd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH + 1),
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/matmul_c_reader.sv
// Matrix-C readback: reads the finished tile out of the C BRAM one row per cycle and
// streams enabled rows over a valid/ready interface, ascending row order.
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   start, clear_done       control handshake (start sampled in IDLE, clear_done in DONE)
//   base_addr, addr_stride  byte address of row 0 and byte distance between rows
//   row_mask, col_mask      rows to emit / columns to keep (others forced to 0)
//   busy, done              READ/DRAIN and DONE indications
//   bram_addr, bram_en      C BRAM read port; bram_rdata valid one cycle after bram_en
//   out_data/row/last/valid stream beat, held stable until out_ready
module matmul_c_reader
    import matmul_c_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         clear_done,
    input  logic [AWIDTH-1:0]            base_addr,
    input  logic [ADDR_STRIDE_WIDTH-1:0] addr_stride,
    input  logic [MASK_WIDTH-1:0]        row_mask,
    input  logic [MASK_WIDTH-1:0]        col_mask,
    output logic                         busy,
    output logic                         done,
    output logic [AWIDTH-1:0]            bram_addr,
    output logic                         bram_en,
    input  logic [ROW_BITS-1:0]          bram_rdata,
    output logic [ROW_BITS-1:0]          out_data,
    output logic [LOG2_MAT_MUL_SIZE-1:0] out_row,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    mm_state_e                     state_q, state_d;
    logic [AWIDTH-1:0]             base_q;
    logic [ADDR_STRIDE_WIDTH-1:0]  stride_q;
    logic [MASK_WIDTH-1:0]         col_mask_q;
    logic [MASK_WIDTH-1:0]         rows_left_q;

    logic                          inflight_q;
    logic [LOG2_MAT_MUL_SIZE-1:0]  inflight_row_q;
    logic                          inflight_last_q;

    logic                          accept;
    logic                          issue;
    logic                          can_issue;
    logic                          drain_done;
    logic [LOG2_MAT_MUL_SIZE-1:0]  issue_row;
    logic [MASK_WIDTH-1:0]         rows_after;
    logic                          issue_last;
    logic [ROW_BITS-1:0]           masked_rdata;

    logic                          fifo_push;
    logic                          fifo_pop;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [CntW-1:0]               fifo_count;
    logic [FIFO_WIDTH-1:0]         fifo_wdata;
    logic [FIFO_WIDTH-1:0]         fifo_rdata;

    assign accept = (state_q == StIdle) && start;

    // Next row to read is the lowest row still pending.
    always_comb begin
        issue_row = '0;
        for (int i = MASK_WIDTH - 1; i >= 0; i--) begin
            if (rows_left_q[i]) issue_row = LOG2_MAT_MUL_SIZE'(i);
        end
    end

    assign rows_after = rows_left_q & ~(MASK_WIDTH'(1) << issue_row);
    assign issue_last = (rows_after == '0);

    // Free slots = depth - buffered - in flight, plus the slot freed by this cycle's pop.
    assign can_issue = (32'(fifo_count) + 32'(inflight_q)) < (FIFO_DEPTH + 32'(fifo_pop));

    // Empty as of the next cycle, so done follows the last transfer without a bubble.
    assign drain_done = !inflight_q &&
                        (fifo_empty || ((fifo_count == CntW'(1)) && fifo_pop));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = (row_mask == '0) ? StDone : StRead;
            end
            StRead: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (issue_last) state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_done) state_d = StDone;
            end
            StDone: begin
                if (clear_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= StIdle;
            base_q          <= '0;
            stride_q        <= '0;
            col_mask_q      <= '0;
            rows_left_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_row_q  <= '0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                base_q      <= base_addr;
                stride_q    <= addr_stride;
                col_mask_q  <= col_mask;
                rows_left_q <= row_mask;
            end else if (issue) begin
                rows_left_q <= rows_after;
            end
            inflight_q <= issue;
            if (issue) begin
                inflight_row_q  <= issue_row;
                inflight_last_q <= issue_last;
            end
        end
    end

    assign bram_en   = issue;
    assign bram_addr = issue ? row_byte_addr(base_q, stride_q, issue_row) : '0;
    assign busy      = (state_q == StRead) || (state_q == StDrain);
    assign done      = (state_q == StDone);

    always_comb begin
        masked_rdata = '0;
        for (int c = 0; c < MAT_MUL_SIZE; c++) begin
            if (col_mask_q[c]) masked_rdata[c*DWIDTH +: DWIDTH] = bram_rdata[c*DWIDTH +: DWIDTH];
        end
    end

    // Credit keeps the FIFO from overflowing; the full guard is a backstop only.
    assign fifo_wdata = {inflight_row_q, inflight_last_q, masked_rdata};
    assign fifo_push  = inflight_q && (!fifo_full || fifo_pop);
    assign fifo_pop   = out_valid && out_ready;

    mm_rd_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .wdata  (fifo_wdata),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Outputs read zero while nothing is buffered.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_rdata[ROW_BITS-1:0];
    assign out_last  = !fifo_empty && fifo_rdata[ROW_BITS];
    assign out_row   = fifo_empty ? '0 : fifo_rdata[FIFO_WIDTH-1 -: LOG2_MAT_MUL_SIZE];

endmodule

// File: tb/tb_matmul_c_reader.sv
module tb_matmul_c_reader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        clear_done = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [7:0]  addr_stride = '0;
    logic [3:0]  row_mask = '0;
    logic [3:0]  col_mask = '0;
    logic        busy;
    logic        done;
    logic [9:0]  bram_addr;
    logic        bram_en;
    logic [31:0] bram_rdata = '0;
    logic [31:0] out_data;
    logic [1:0]  out_row;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    matmul_c_reader #(
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .clear_done  (clear_done),
        .base_addr   (base_addr),
        .addr_stride (addr_stride),
        .row_mask    (row_mask),
        .col_mask    (col_mask),
        .busy        (busy),
        .done        (done),
        .bram_addr   (bram_addr),
        .bram_en     (bram_en),
        .bram_rdata  (bram_rdata),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    // C BRAM model: one-cycle read latency, byte-addressed words.
    logic [31:0] bram_mem [1024];
    always @(posedge clk) begin
        if (bram_en) bram_rdata <= bram_mem[bram_addr];
    end

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  row;
        logic        last;
    } beat_t;

    beat_t      exp_q[$];
    logic [9:0] addr_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- ready driver ----------------
    int ready_mode = 0;   // 0 high, 1 pattern 1,0,0, 2 low, 3 high until ready_stop beats
    int ready_stop = 0;
    int rptr = 0;
    int beats = 0;

    initial forever begin
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = (rptr % 3 == 0);
            3: out_ready = (beats < ready_stop);
            default: out_ready = 1'b0;
        endcase
        rptr++;
        @(posedge clk);
        #1;
    end

    // ---------------- monitor / scoreboard ----------------
    int exp_en_cyc = -1;
    int exp_valid_cyc = -1;
    int exp_done_cyc = -1;
    int issued = 0;
    int xfers = 0;
    bit prev_stall = 1'b0;
    beat_t prev_beat;

    always @(negedge clk) begin
        beat_t got;
        beat_t e;
        logic [9:0] ea;
        bit xfer;
        got  = {out_data, out_row, out_last};
        xfer = out_valid && out_ready;
        if (!resetn) begin
            issued     = 0;
            xfers      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check(out_valid && got == prev_beat, "stall_hold", {out_valid, got}, {1'b1, prev_beat});
            if (bram_en) begin
                check((issued - xfers) + 1 - int'(xfer) <= 2, "credit", issued - xfers, 2);
                check(addr_q.size() > 0, "issue_expected", addr_q.size(), 1);
                if (addr_q.size() > 0) begin
                    ea = addr_q.pop_front();
                    check(bram_addr == ea, "bram_addr", bram_addr, ea);
                end
                if (exp_en_cyc >= 0) begin
                    check(cyc == exp_en_cyc, "first_en_cycle", cyc, exp_en_cyc);
                    exp_en_cyc = -1;
                end
                issued++;
            end
            if (out_valid && exp_valid_cyc >= 0) begin
                check(cyc == exp_valid_cyc, "first_valid_cycle", cyc, exp_valid_cyc);
                exp_valid_cyc = -1;
            end
            if (done && exp_done_cyc >= 0) begin
                check(cyc == exp_done_cyc, "done_cycle", cyc, exp_done_cyc);
                exp_done_cyc = -1;
            end
            if (xfer) begin
                check(exp_q.size() > 0, "beat_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(got == e, "beat", got, e);
                end
                xfers++;
                beats++;
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = got;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic [1:0] r, input logic l);
        beat_t b;
        b = {d, r, l};
        exp_q.push_back(b);
    endtask

    task automatic expect_full_tile();
        addr_q.push_back(10'h040);
        addr_q.push_back(10'h044);
        addr_q.push_back(10'h048);
        addr_q.push_back(10'h04C);
        exp_beat(32'h03020100, 2'd0, 1'b0);
        exp_beat(32'h07060504, 2'd1, 1'b0);
        exp_beat(32'h0B0A0908, 2'd2, 1'b0);
        exp_beat(32'h0F0E0D0C, 2'd3, 1'b1);
    endtask

    // Drives start for one cycle; inputs are scrambled afterwards to prove they were latched.
    task automatic start_tile(input logic [9:0] b, input logic [7:0] s, input logic [3:0] rm,
                              input logic [3:0] cm, input bit timed, input int done_off);
        int e;
        base_addr   = b;
        addr_stride = s;
        row_mask    = rm;
        col_mask    = cm;
        start       = 1'b1;
        e = cyc + 1;
        exp_en_cyc    = (timed && rm != 0) ? e : -1;
        exp_valid_cyc = (timed && rm != 0) ? e + 2 : -1;
        exp_done_cyc  = timed ? e + done_off : -1;
        tick();
        start       = 1'b0;
        base_addr   = ~b;
        addr_stride = 8'h55;
        row_mask    = ~rm;
        col_mask    = ~cm;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(done === 1'b1, {name, "_done"}, done, 1);
        check(exp_q.size() == 0 && addr_q.size() == 0, {name, "_drained"},
              exp_q.size() + addr_q.size(), 0);
    endtask

    task automatic finish_tile(input string name);
        wait_done(name);
        tick();
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({busy, done, bram_en, out_valid, out_last, bram_addr, out_data, out_row} == 0, name,
              {busy, done, bram_en, out_valid, out_last, bram_addr, out_data, out_row}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        for (int i = 0; i < 1024; i++) bram_mem[i] = 32'hDEAD0000 | i;
        bram_mem[10'h040] = 32'h03020100;
        bram_mem[10'h044] = 32'h07060504;
        bram_mem[10'h048] = 32'h0B0A0908;
        bram_mem[10'h04C] = 32'h0F0E0D0C;
        bram_mem[10'h3FC] = 32'hA3A2A1A0;
        bram_mem[10'h004] = 32'hB3B2B1B0;
        bram_mem[10'h00C] = 32'hC3C2C1C0;
        bram_mem[10'h014] = 32'hD3D2D1D0;

        resetn = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_state");
        resetn = 1'b1;
        tick();

        // 1: full tile, no backpressure; timing N+1 / N+3 / N+7
        expect_full_tile();
        start_tile(10'h040, 8'd4, 4'hF, 4'hF, 1'b1, 6);
        finish_tile("full_tile");

        // 2: backpressure 1,0,0 pattern
        ready_mode = 1;
        expect_full_tile();
        start_tile(10'h040, 8'd4, 4'hF, 4'hF, 1'b0, 0);
        finish_tile("backpressure");
        ready_mode = 0;

        // 3: row and column masks
        addr_q.push_back(10'h044);
        addr_q.push_back(10'h04C);
        exp_beat(32'h00060500, 2'd1, 1'b0);
        exp_beat(32'h000E0D00, 2'd3, 1'b1);
        start_tile(10'h040, 8'd4, 4'b1010, 4'b0110, 1'b1, 4);
        finish_tile("masks");

        // 4a: empty row mask goes straight to done
        start_tile(10'h040, 8'd4, 4'h0, 4'hF, 1'b1, 0);
        finish_tile("empty_mask");

        // 4b: address wrap
        addr_q.push_back(10'h3FC);
        addr_q.push_back(10'h004);
        addr_q.push_back(10'h00C);
        addr_q.push_back(10'h014);
        exp_beat(32'hA3A2A1A0, 2'd0, 1'b0);
        exp_beat(32'hB3B2B1B0, 2'd1, 1'b0);
        exp_beat(32'hC3C2C1C0, 2'd2, 1'b0);
        exp_beat(32'hD3D2D1D0, 2'd3, 1'b1);
        start_tile(10'h3FC, 8'd8, 4'hF, 4'hF, 1'b1, 6);
        finish_tile("wrap");

        // 5: start/clear_done while busy ignored; restart right after clear_done
        expect_full_tile();
        start_tile(10'h040, 8'd4, 4'hF, 4'hF, 1'b0, 0);
        start      = 1'b1;
        clear_done = 1'b1;
        row_mask   = 4'h0;
        tick();
        start      = 1'b0;
        clear_done = 1'b0;
        check(busy === 1'b1 && done === 1'b0, "busy_ignores_ctrl", {busy, done}, 2'b10);
        wait_done("ctrl");
        tick();
        check(done === 1'b1, "done_held", done, 1);
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        check(done === 1'b0 && busy === 1'b0, "clear_to_idle", {done, busy}, 0);
        addr_q.push_back(10'h040);
        exp_beat(32'h03020100, 2'd0, 1'b1);
        start_tile(10'h040, 8'd4, 4'b0001, 4'hF, 1'b1, 3);
        finish_tile("restart");

        // 6: reset mid-tile after two beats, then a fresh full tile
        ready_stop = beats + 2;
        ready_mode = 3;
        expect_full_tile();
        start_tile(10'h040, 8'd4, 4'hF, 4'hF, 1'b0, 0);
        n = 0;
        while (beats < ready_stop && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(beats >= ready_stop, "two_beats_before_reset", beats, ready_stop);
        tick();
        resetn = 1'b0;
        exp_q.delete();
        addr_q.delete();
        exp_en_cyc    = -1;
        exp_valid_cyc = -1;
        exp_done_cyc  = -1;
        tick();
        check_all_zero("mid_tile_reset");
        resetn     = 1'b1;
        ready_mode = 0;
        tick();
        expect_full_tile();
        start_tile(10'h040, 8'd4, 4'hF, 4'hF, 1'b1, 6);
        finish_tile("after_reset");

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
